// File: rtl/uart_tx_buffered.sv
// UART transmitter with a write FIFO, per-frame baud/parity/stop selection.
// Words are queued with wr_en and sent back-to-back. Each frame latches its
// own configuration at pop time, so config changes only affect later frames.
//
// Write side: wr_en is a one-cycle push with no ready handshake. A push is
// accepted when the FIFO is not full, or when it is full but a pop happens
// in the same cycle. Otherwise the word is dropped and overflow pulses for
// one cycle. full and fifo_count reflect the state after the clock edge.
module uart_tx_buffered #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              wr_en,
    input  logic [DATA_BITS-1:0]              wr_data,
    input  logic [2:0]                        BR_Select,
    input  logic [1:0]                        parity_mode,
    input  logic                              two_stop,
    output logic                              Tx,
    output logic                              busy,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

    // Clocks per bit, indexed by BR_Select (entry 0 = 300 baud).
    localparam logic [7:0][31:0] DIV_TABLE = {
        32'(CLK_HZ / 115200), 32'(CLK_HZ / 57600), 32'(CLK_HZ / 19200),
        32'(CLK_HZ / 9600),   32'(CLK_HZ / 4800),  32'(CLK_HZ / 2400),
        32'(CLK_HZ / 1200),   32'(CLK_HZ / 300)
    };

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 fifo_empty;
    logic                 push_ok;
    logic                 pop;

    // Frame engine
    logic [2:0]           state;
    logic [31:0]          baud_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_second;
    logic [DATA_BITS-1:0] frame_data;
    logic [31:0]          frame_div;
    logic [1:0]           frame_par;
    logic                 frame_two;
    logic                 bit_done;
    logic                 last_stop;
    logic                 parity_on;
    logic                 parity_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_next;

    assign fifo_empty = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign busy       = (state != ST_IDLE);

    // Pop/push decisions and the combinational next value of the line
    always_comb begin
        bit_done   = (baud_cnt == frame_div - 32'd1);
        last_stop  = (state == ST_STOP) && bit_done && (!frame_two || stop_second);
        pop        = !fifo_empty && ((state == ST_IDLE) || last_stop);
        push_ok    = wr_en && (!full || pop);
        parity_on  = frame_par[0] ^ frame_par[1];
        parity_bit = (frame_par == 2'b10) ? ~^frame_data : ^frame_data;
        tx_shift   = frame_data >> bit_idx;
        tx_next    = 1'b1;
        case (state)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = tx_shift[0];
            ST_PARITY: tx_next = parity_bit;
            default:   tx_next = 1'b1;
        endcase
    end

    // FIFO storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame sequencer: a pop always starts a new frame with fresh config
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            frame_data  <= '0;
            frame_div   <= DIV_TABLE[7];
            frame_par   <= 2'b00;
            frame_two   <= 1'b0;
        end else if (pop) begin
            state       <= ST_START;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            frame_data  <= mem[rd_ptr];
            frame_div   <= DIV_TABLE[BR_Select];
            frame_par   <= parity_mode;
            frame_two   <= two_stop;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                end
                ST_START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == BITS_LAST) begin
                            stop_second <= 1'b0;
                            state       <= parity_on ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        baud_cnt    <= '0;
                        stop_second <= 1'b0;
                        state       <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (frame_two && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered line driver; trails the state by one clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Tx <= 1'b1;
        end else begin
            Tx <= tx_next;
        end
    end

endmodule
